// File: rtl/ddc_feeder_pkg.sv
// rtl/ddc_feeder_pkg.sv - shared widths, IQ sample type and round/saturate helper for ddc_i2s_feeder
// Contents:
//   IN_W_DEF / OUT_W_DEF : default DDC input and I2S output sample widths
//   iq_sample_t          : packed {re, im} sample at the default output width
//   round_sat()          : round-half-up arithmetic right shift, then clamp to a signed out_w range
package ddc_feeder_pkg;

    localparam int IN_W_DEF  = 32;
    localparam int OUT_W_DEF = 24;

    typedef struct packed {
        logic signed [OUT_W_DEF-1:0] re;
        logic signed [OUT_W_DEF-1:0] im;
    } iq_sample_t;

    // Operates at 64 bits so the rounding constant can never overflow the
    // scaled product; callers truncate the clamped result to their width.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] p,
        input int unsigned        shift,
        input int unsigned        out_w
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = p;
        if (shift > 0) begin
            r = (p + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_sample_fifo.sv
// rtl/iq_sample_fifo.sv - synchronous IQ sample FIFO with occupancy count
// Ports:
//   SAICLK, reset      : clock, synchronous active-high reset
//   clear              : synchronous flush (pointers and level to 0)
//   push, wdata        : write request; dropped when full unless a pop happens the same cycle
//   pop, rdata         : read request; rdata shows the head entry combinationally
//   full, empty, level : occupancy status
module iq_sample_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                     SAICLK,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge SAICLK) begin
        if (reset || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (AW + 1)'(1);
            end else if (!do_push && do_pop) begin
                level <= level - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge SAICLK) begin
        if (do_push && !reset && !clear) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/ddc_i2s_feeder.sv
// rtl/ddc_i2s_feeder.sv - scales DDC IQ samples into an I2S frame FIFO paced by the word clock
// Ports:
//   SAICLK, reset               : clock, synchronous active-high reset
//   run                         : low flushes the FIFO and forces zero output samples
//   in_valid, in_real, in_imag  : DDC sample strobe and signed IN_W I/Q data
//   gain_shift                  : left-shift gain 0..7 applied with each sample
//   lrclk_async                 : I2S word clock from the BCLK domain
//   rx_real, rx_imag, frame_stb : held OUT_W output samples and their one-cycle update strobe
//   fifo_level                  : FIFO occupancy
//   overrun_cnt, underrun_cnt   : saturating event counters, cleared by stats_clr
// Build option: DDC_FEEDER_STATS_EN implements the counters; otherwise they read 0.
module ddc_i2s_feeder
    import ddc_feeder_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                     SAICLK,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     in_valid,
    input  logic signed [IN_W-1:0]   in_real,
    input  logic signed [IN_W-1:0]   in_imag,
    input  logic [2:0]               gain_shift,
    input  logic                     lrclk_async,
    input  logic                     stats_clr,
    output logic signed [OUT_W-1:0]  rx_real,
    output logic signed [OUT_W-1:0]  rx_imag,
    output logic                     frame_stb,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              overrun_cnt,
    output logic [15:0]              underrun_cnt
);

    localparam int PW    = IN_W + 8;
    localparam int SHIFT = IN_W - OUT_W;

    logic                   lr_s1, lr_s2, lr_s3;
    logic                   frame_pulse;
    logic                   v1, v2;
    logic signed [PW-1:0]   p_re, p_im;
    logic signed [OUT_W-1:0] q_re, q_im;
    logic [2*OUT_W-1:0]     fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop, loaded;
    logic                   ovr_inc, und_inc;

    assign push    = v2 & run;
    assign pop     = frame_pulse & run;
    assign loaded  = pop & ~fifo_empty;
    // A full FIFO is never empty, so any pop this cycle makes room for the write.
    assign ovr_inc = push & fifo_full & ~pop;
    assign und_inc = pop & fifo_empty;

    always_ff @(posedge SAICLK) begin
        if (reset) begin
            lr_s1       <= 1'b0;
            lr_s2       <= 1'b0;
            lr_s3       <= 1'b0;
            frame_pulse <= 1'b0;
            frame_stb   <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            rx_real     <= '0;
            rx_imag     <= '0;
        end else begin
            lr_s1       <= lrclk_async;
            lr_s2       <= lr_s1;
            lr_s3       <= lr_s2;
            frame_pulse <= lr_s3 & ~lr_s2;
            // The strobe follows every frame pulse, even while stopped or starved,
            // so the transmitter always sees a frame boundary.
            frame_stb   <= frame_pulse;
            v1          <= in_valid & run;
            v2          <= v1 & run;
            if (!run) begin
                rx_real <= '0;
                rx_imag <= '0;
            end else if (loaded) begin
                {rx_real, rx_imag} <= fifo_rdata;
            end
        end
    end

    // Datapath stages carry no reset; the valid bits above qualify them.
    always_ff @(posedge SAICLK) begin
        if (in_valid) begin
            p_re <= PW'(in_real) <<< gain_shift;
            p_im <= PW'(in_imag) <<< gain_shift;
        end
        if (v1) begin
            q_re <= OUT_W'(round_sat(64'(p_re), SHIFT, OUT_W));
            q_im <= OUT_W'(round_sat(64'(p_im), SHIFT, OUT_W));
        end
    end

    iq_sample_fifo #(
        .W     (2 * OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .SAICLK (SAICLK),
        .reset  (reset),
        .clear  (~run),
        .push   (push),
        .wdata  ({q_re, q_im}),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

`ifdef DDC_FEEDER_STATS_EN
    logic [15:0] ovr_q;
    logic [15:0] und_q;

    always_ff @(posedge SAICLK) begin
        if (reset || stats_clr) begin
            ovr_q <= '0;
            und_q <= '0;
        end else begin
            if (ovr_inc && ovr_q != 16'hFFFF) begin
                ovr_q <= ovr_q + 16'd1;
            end
            if (und_inc && und_q != 16'hFFFF) begin
                und_q <= und_q + 16'd1;
            end
        end
    end

    assign overrun_cnt  = ovr_q;
    assign underrun_cnt = und_q;
`else
    logic unused_stats;
    assign unused_stats = stats_clr ^ ovr_inc ^ und_inc;
    assign overrun_cnt  = '0;
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_ddc_i2s_feeder.sv
// tb/tb_ddc_i2s_feeder.sv - self-checking bench for ddc_i2s_feeder (table vectors, corner sequences, random vs model)
module tb_ddc_i2s_feeder;
    import ddc_feeder_pkg::*;

    localparam int DEPTH = 4;
`ifdef DDC_FEEDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        SAICLK = 1'b0;
    logic        reset, run, in_valid, lrclk_async, stats_clr;
    logic [31:0] in_real, in_imag;
    logic [2:0]  gain_shift;
    logic [23:0] rx_real, rx_imag;
    logic        frame_stb;
    logic [2:0]  fifo_level;
    logic [15:0] overrun_cnt, underrun_cnt;

    always #5 SAICLK = ~SAICLK;

    ddc_i2s_feeder #(.IN_W(32), .OUT_W(24), .DEPTH(DEPTH)) dut (
        .SAICLK       (SAICLK),
        .reset        (reset),
        .run          (run),
        .in_valid     (in_valid),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .gain_shift   (gain_shift),
        .lrclk_async  (lrclk_async),
        .stats_clr    (stats_clr),
        .rx_real      (rx_real),
        .rx_imag      (rx_imag),
        .frame_stb    (frame_stb),
        .fifo_level   (fifo_level),
        .overrun_cnt  (overrun_cnt),
        .underrun_cnt (underrun_cnt)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    iq_sample_t mq[$];
    iq_sample_t last;
    int         m_ovr, m_und;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic [2:0]  g;
        logic [23:0] er;
        logic [23:0] ei;
    } vec_t;
    vec_t tbl[8];

    task automatic tick();
        @(posedge SAICLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ecnt(input int v);
        int s;
        s = (v > 65535) ? 65535 : v;
        return STATS ? 32'(s) : 32'd0;
    endfunction

    // Scale by 2^g, add half an output LSB, floor-divide by 256, clamp to 24 bits.
    function automatic logic [23:0] model_scale(input logic [31:0] x, input logic [2:0] g);
        longint p, q, r;
        p = longint'($signed(x)) * (longint'(1) << g);
        q = p + 128;
        if (q >= 0) r = q / 256;
        else        r = -((-q + 255) / 256);
        if (r > 8388607)  r = 8388607;
        if (r < -8388608) r = -8388608;
        return r[23:0];
    endfunction

    function automatic iq_sample_t mk(input logic [31:0] re, input logic [31:0] im, input logic [2:0] g);
        iq_sample_t s;
        s.re = model_scale(re, g);
        s.im = model_scale(im, g);
        return s;
    endfunction

    task automatic model_push(input iq_sample_t s);
        if (mq.size() < DEPTH) mq.push_back(s);
        else m_ovr++;
    endtask

    task automatic model_pop();
        if (mq.size() > 0) last = mq.pop_front();
        else m_und++;
    endtask

    task automatic model_clear();
        mq.delete();
        last = '0;
    endtask

    task automatic check_state(input string name);
        check({name, " level"}, 32'(fifo_level), 32'(mq.size()));
        check({name, " overrun"}, 32'(overrun_cnt), ecnt(m_ovr));
        check({name, " underrun"}, 32'(underrun_cnt), ecnt(m_und));
    endtask

    task automatic check_rx(input string name);
        check({name, " rx_real"}, 32'(rx_real), 32'($unsigned(last.re)));
        check({name, " rx_imag"}, 32'(rx_imag), 32'($unsigned(last.im)));
    endtask

    task automatic do_write(input logic [31:0] re, input logic [31:0] im, input logic [2:0] g);
        in_valid = 1'b1; in_real = re; in_imag = im; gain_shift = g;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        if (run) model_push(mk(re, im, g));
    endtask

    task automatic do_frame(input string name);
        int lat;
        lat = 0;
        lrclk_async = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (frame_stb) begin
                lat = k;
                break;
            end
        end
        check({name, " stb latency"}, 32'(lat), 32'd4);
        lrclk_async = 1'b1;
        tick(); tick(); tick(); tick();
        if (run) model_pop();
        else last = '0;
        check_rx(name);
    endtask

    // Lines up a write with a frame pulse so push and pop land in the same cycle.
    task automatic coincide(input string name, input logic [31:0] re, input logic [31:0] im);
        lrclk_async = 1'b0;
        tick();
        in_valid = 1'b1; in_real = re; in_imag = im; gain_shift = 3'd0;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check({name, " stb"}, 32'(frame_stb), 32'd1);
        lrclk_async = 1'b1;
        tick(); tick(); tick(); tick();
        model_pop();
        model_push(mk(re, im, 3'd0));
        check_rx(name);
        check_state(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h0000_0180, 32'h0000_0000, 3'd0, 24'h000002, 24'h000000};
        tbl[1] = '{32'h7FFF_FF80, 32'h8000_0000, 3'd0, 24'h7FFFFF, 24'h800000};
        tbl[2] = '{32'h8000_0000, 32'h0000_0180, 3'd0, 24'h800000, 24'h000002};
        tbl[3] = '{32'h0000_0000, 32'h4000_0000, 3'd1, 24'h000000, 24'h7FFFFF};
        tbl[4] = '{32'h0000_0000, 32'h0000_0100, 3'd3, 24'h000000, 24'h000008};
        tbl[5] = '{32'hFFFF_FF80, 32'hFFFF_FE80, 3'd0, 24'h000000, 24'hFFFFFF};
        tbl[6] = '{32'h0000_0080, 32'h0000_007F, 3'd0, 24'h000001, 24'h000000};
        tbl[7] = '{32'h0100_0000, 32'hFF00_0000, 3'd7, 24'h7FFFFF, 24'h800000};

        reset = 1'b1; run = 1'b1; in_valid = 1'b0; lrclk_async = 1'b1; stats_clr = 1'b0;
        in_real = '0; in_imag = '0; gain_shift = '0;
        m_ovr = 0; m_und = 0; last = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("reset rx_real", 32'(rx_real), 32'd0);
        check("reset rx_imag", 32'(rx_imag), 32'd0);
        check("reset frame_stb", 32'(frame_stb), 32'd0);
        check_state("reset");
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                tick();
                if (frame_stb) seen++;
            end
            check("no spurious frame", 32'(seen), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            do_write(tbl[i].re, tbl[i].im, tbl[i].g);
            do_frame($sformatf("vec%0d", i));
            check($sformatf("vec%0d table re", i), 32'(rx_real), 32'(tbl[i].er));
            check($sformatf("vec%0d table im", i), 32'(rx_imag), 32'(tbl[i].ei));
        end

        // Six back-to-back writes into a four-entry FIFO.
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_real = 32'(i) << 8; in_imag = -(32'(i) << 8); gain_shift = 3'd0;
            tick();
            model_push(mk(32'(i) << 8, -(32'(i) << 8), 3'd0));
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check_state("overrun");
        for (int i = 1; i <= 4; i++) begin
            do_frame($sformatf("drain%0d", i));
            check($sformatf("drain%0d order", i), 32'(rx_real), 32'(i));
        end

        stats_clr = 1'b1; tick(); stats_clr = 1'b0;
        m_ovr = 0; m_und = 0;
        for (int i = 0; i < 3; i++) do_frame($sformatf("underrun%0d", i));
        check_state("underrun");

        for (int i = 1; i <= 3; i++) do_write(32'(i) << 12, 32'(i) << 10, 3'd0);
        check_state("loaded3");
        run = 1'b0;
        tick(); tick();
        model_clear();
        check_state("run low");
        check_rx("run low");
        do_frame("frame while stopped");
        check_state("stopped no count");
        run = 1'b1;
        tick();

        in_valid = 1'b1; in_real = 32'h0001_0000; in_imag = 32'h0002_0000;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        model_clear(); m_ovr = 0; m_und = 0;
        check_state("reset in flight");
        check_rx("reset in flight");

        for (int i = 1; i <= 4; i++) do_write(32'(i) << 9, 32'(i) << 11, 3'd0);
        coincide("push+pop full", 32'h0000_5500, 32'hFFFF_AB00);
        for (int i = 1; i <= 4; i++) do_frame($sformatf("full drain%0d", i));
        coincide("push+pop empty", 32'h0000_3300, 32'h0000_4400);
        do_frame("empty follow-up");
        check_state("after boundary");

        lrclk_async = 1'b0;
        tick(); tick(); tick();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("clr frame_stb", 32'(frame_stb), 32'd1);
        lrclk_async = 1'b1;
        repeat (4) tick();
        m_ovr = 0; m_und = 0;
        check_state("clr beats increment");

`ifdef DDC_FEEDER_STATS_EN
        force dut.und_q = 16'hFFFE;
        tick();
        release dut.und_q;
        m_und = 65534;
        do_frame("sat a");
        do_frame("sat b");
        check_state("underrun saturated");
        stats_clr = 1'b1; tick(); stats_clr = 1'b0;
        m_ovr = 0; m_und = 0;
`endif

        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op < 10) begin
                logic [31:0] re, im;
                re = $urandom; im = $urandom;
                if ($urandom_range(0, 1) == 1) re = $signed(re) >>> $urandom_range(8, 28);
                if ($urandom_range(0, 1) == 1) im = $signed(im) >>> $urandom_range(8, 28);
                do_write(re, im, 3'($urandom_range(0, 7)));
            end else if (op < 19) begin
                do_frame($sformatf("rand frame %0d", n));
            end else begin
                run = 1'b0;
                tick(); tick();
                model_clear();
                check_rx($sformatf("rand stop %0d", n));
                run = 1'b1;
                tick();
            end
            check_state($sformatf("rand %0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ddc_i2s_feeder.md
DDC_I2S_FEEDER -- requirements
Module: ddc_i2s_feeder

Interface
REQ-001 Parameter IN_W, default 32: signed DDC output sample width.
REQ-002 Parameter OUT_W, default 24: signed sample width presented to the I2S slave.
REQ-003 Parameter DEPTH, default 4 (power of 2, >=2): IQ FIFO entries.
REQ-004 clock  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 run  in  1  high = normal operation; low = flush FIFO and drive zero samples.
REQ-007 in_valid  in  1  one-cycle strobe qualifying in_real/in_imag.
REQ-008 in_real, in_imag  in  IN_W each  signed DDC I/Q samples.
REQ-009 gain_shift  in  3  left-shift gain 0..7, sampled on in_valid.
REQ-010 lrclk_async  in  1  I2S word clock from the BCLK domain, asynchronous to clock.
REQ-011 rx_real, rx_imag  out  OUT_W each  samples feeding the I2S transmitter, held between frames.
REQ-012 frame_stb  out  1  one-cycle pulse when rx_real/rx_imag update.
REQ-013 fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overrun_cnt, underrun_cnt  out  16 each  saturating event counters.
REQ-015 stats_clr  in  1  synchronous clear of both counters.

Function
REQ-016 Scaling: p = in * 2^gain_shift at IN_W+8 bits; out = (p + 2^(IN_W-OUT_W-1)) >>> (IN_W-OUT_W), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-017 Scaling is a 2-stage pipeline: the FIFO write occurs exactly 2 cycles after in_valid.
REQ-018 FIFO entry = {real, imag}, 2*OUT_W bits; pointers wrap modulo DEPTH.
REQ-019 lrclk_async passes through a 2-FF synchronizer, then a falling-edge detector; frame pulse occurs 3 cycles after a falling edge is present at the input.
REQ-020 On frame pulse with FIFO non-empty: pop, load rx_real/rx_imag on the next cycle, and assert frame_stb in that same cycle.
REQ-021 On frame pulse with FIFO empty: outputs hold their previous values, underrun_cnt += 1, and frame_stb is still asserted.
REQ-022 On write with FIFO full and no pop in the same cycle: drop the new sample and increment overrun_cnt.
REQ-023 Simultaneous write and pop when full: both occur, no overrun, level unchanged.
REQ-024 Simultaneous write and pop when empty: underrun counted, the write stored, level becomes 1, no bypass.
REQ-025 Counters saturate at 0xFFFF; stats_clr takes priority over a same-cycle increment.
REQ-026 run low: FIFO emptied, pipeline valids cleared, rx_real/rx_imag = 0, no counting; while low, frame_stb still pulses on frame pulses.
REQ-027 Between frame_stb pulses, rx_real/rx_imag do not change; the downstream CDC relies on this.

Reset
REQ-028 reset clears: rx_real, rx_imag, frame_stb, fifo_level, both counters, both pointers, pipeline valids, and all synchronizer and edge flops (all to 0).
REQ-029 Synchronizer flops reset to 0, so a high lrclk after reset produces no spurious frame pulse.
REQ-030 Reset mid-operation discards in-flight pipeline samples and FIFO contents within the reset cycle.

Configuration
REQ-031 Macro DDC_FEEDER_STATS_EN defined: overrun_cnt and underrun_cnt are implemented per REQ-014/021/022/025.
REQ-032 Macro DDC_FEEDER_STATS_EN undefined: the counter ports remain present, are tied to 0, stats_clr is ignored, and no counter flops are implemented.

Structure
REQ-033 Package ddc_feeder_pkg holds IN_W/OUT_W default constants, the iq_sample_t typedef {real, imag}, and the round/saturate function.
REQ-034 Sub-module iq_sample_fifo is the synchronous FIFO (push, pop, full, empty, level); the scaler and frame logic live in ddc_i2s_feeder.

Verification
REQ-035 Scaling check, gain 0:
- in_real=0x00000180 -> rx_real=0x000002.
- in_real=0x7FFFFF80 -> 0x7FFFFF (saturated).
- in_real=0x80000000 -> 0x800000.
REQ-036 Gain check: gain_shift=1, in_imag=0x40000000 -> rx_imag=0x7FFFFF; gain_shift=3, in_imag=0x00000100 -> 0x000008.
REQ-037 Overrun check: DEPTH=4, write 6 samples with no lrclk edges -> fifo_level=4, overrun_cnt=2, and the next 4 frames output samples 1-4.
REQ-038 Underrun check: empty FIFO, 3 lrclk falling edges -> underrun_cnt=3, 3 frame_stb pulses, outputs unchanged; frame_stb lags each falling edge by 4 cycles.
REQ-039 Run/reset check: load 3 samples, drop run -> fifo_level=0, outputs 0; reset asserted with in_valid in flight -> nothing written after reset.
REQ-040 Boundary check: push and pop in the same cycle at full and at empty -> behaviour per REQ-023/024; counters at 0xFFFF stay saturated; stats_clr plus increment -> 0.
